// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo ramp sequencer.
// Setpoints are 7-bit signed, range -63..+63.
package servo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP0,
    STEP1
  } state_e;

  localparam logic CH_FULLROT = 1'b0;
  localparam logic CH_NORMAL  = 1'b1;

  localparam int unsigned SIM_STEP_CYCLES = 16;

  function automatic logic signed [6:0] sp_encode(
    input logic       dir,
    input logic [5:0] mag
  );
    logic signed [6:0] m;
    m = $signed({1'b0, mag});
    // negating zero yields zero, so -0 never exists
    return dir ? m : -m;
  endfunction

  function automatic logic [5:0] sp_mag(
    input logic signed [6:0] v
  );
    return 6'(v[6] ? -v : v);
  endfunction

  function automatic logic sp_dir(
    input logic signed [6:0] v
  );
    return ~v[6];
  endfunction

endpackage

// File: rtl/servo_step_timer.sv
// Free-running step counter, 0..PERIOD-1.
// tick is high for the single cycle the count sits at PERIOD-1.
module servo_step_timer #(
  parameter int unsigned PERIOD = 16
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/servo_ramp_sequencer.sv
// Two-channel setpoint ramp sequencer feeding servo_controller.
// Each step period slews channel 0 then channel 1 by one unit.
module servo_ramp_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 2_000_000,
  parameter int unsigned SIMULATE    = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_servo,
  input  logic       cmd_dir,
  input  logic [5:0] cmd_target,
  input  logic       cmd_jump,
  output logic       direction,
  output logic [5:0] speed_angle,
  output logic       servo_select,
  output logic [1:0] at_target,
  output logic       busy
);

  localparam int unsigned P =
    (SIMULATE != 0) ? SIM_STEP_CYCLES : STEP_CYCLES;

  function automatic logic signed [6:0] slew(
    input logic signed [6:0] c,
    input logic signed [6:0] t
  );
    logic signed [6:0] r;
    r = c;
    unique case (1'b1)
      (c < t): r = c + 7'sd1;
      (c > t): r = c - 7'sd1;
      default: r = c;
    endcase
    return r;
  endfunction

  logic tick;

  servo_step_timer #(
    .PERIOD (P)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  state_e            state_q, state_d;
  logic signed [6:0] cur_q [2];
  logic signed [6:0] cur_d [2];
  logic signed [6:0] tgt_q [2];
  logic signed [6:0] tgt_d [2];
  logic              act_q, act_d;
  logic              ready_q;
  logic              accept;
  logic signed [6:0] enc;

  assign cmd_ready = ready_q;
  assign accept    = cmd_valid & ready_q;
  assign enc       = sp_encode(cmd_dir, cmd_target);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tick) state_d = STEP0;
      STEP0:   state_d = STEP1;
      STEP1:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // a same-cycle command overrides the step; non-jump keeps the old-target step
  always_comb begin
    cur_d = cur_q;
    tgt_d = tgt_q;
    act_d = act_q;
    if (state_q == STEP0) begin
      cur_d[CH_FULLROT] = slew(cur_q[CH_FULLROT], tgt_q[CH_FULLROT]);
    end
    if (state_q == STEP1) begin
      cur_d[CH_NORMAL] = slew(cur_q[CH_NORMAL], tgt_q[CH_NORMAL]);
    end
    if (accept) begin
      tgt_d[cmd_servo] = enc;
      act_d            = cmd_servo;
      if (cmd_jump) begin
        cur_d[cmd_servo] = enc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '{default: '0};
      tgt_q   <= '{default: '0};
      act_q   <= CH_FULLROT;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      act_q   <= act_d;
      ready_q <= 1'b1;
    end
  end

  logic [1:0] match;

  assign match = {cur_q[1] == tgt_q[1], cur_q[0] == tgt_q[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      direction    <= 1'b1;
      speed_angle  <= '0;
      servo_select <= CH_FULLROT;
      at_target    <= 2'b11;
      busy         <= 1'b0;
    end else begin
      direction    <= sp_dir(cur_q[act_q]);
      speed_angle  <= sp_mag(cur_q[act_q]);
      servo_select <= act_q;
      at_target    <= match;
      busy         <= ~&match;
    end
  end

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Directed bench for servo_ramp_sequencer.
// Jump table plus ramp, reversal, collision, reset and period sequences.
module tb_servo_ramp_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_servo = 1'b0;
  logic       cmd_dir = 1'b0;
  logic [5:0] cmd_target = '0;
  logic       cmd_jump = 1'b0;
  logic       cmd_ready;
  logic       direction;
  logic [5:0] speed_angle;
  logic       servo_select;
  logic [1:0] at_target;
  logic       busy;

  logic       v2 = 1'b0;
  logic       s2 = 1'b0;
  logic       d2 = 1'b0;
  logic [5:0] t2 = '0;
  logic       j2 = 1'b0;
  logic       rdy2;
  logic       dir2;
  logic [5:0] sa2;
  logic       sel2;
  logic [1:0] at2;
  logic       busy2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  servo_ramp_sequencer #(
    .SIMULATE (1)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_servo    (cmd_servo),
    .cmd_dir      (cmd_dir),
    .cmd_target   (cmd_target),
    .cmd_jump     (cmd_jump),
    .direction    (direction),
    .speed_angle  (speed_angle),
    .servo_select (servo_select),
    .at_target    (at_target),
    .busy         (busy)
  );

  servo_ramp_sequencer #(
    .STEP_CYCLES (6),
    .SIMULATE    (0)
  ) dut2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (v2),
    .cmd_ready    (rdy2),
    .cmd_servo    (s2),
    .cmd_dir      (d2),
    .cmd_target   (t2),
    .cmd_jump     (j2),
    .direction    (dir2),
    .speed_angle  (sa2),
    .servo_select (sel2),
    .at_target    (at2),
    .busy         (busy2)
  );

  always #5 clk = ~clk;

  // clocks since reset release; step counter phase = cyc % 16
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  typedef struct {
    logic       s;
    logic       d;
    logic [5:0] t;
    int         e_sa;
    int         e_dir;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic send(input logic s, input logic d,
                      input logic [5:0] t, input logic j);
    cmd_servo  = s;
    cmd_dir    = d;
    cmd_target = t;
    cmd_jump   = j;
    cmd_valid  = 1'b1;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % 16) != ph && n < 40);
    if ((cyc % 16) != ph) begin
      n_cmp++;
      n_bad++;
      $display("FAIL phase_wait: got %0d want %0d", cyc % 16, ph);
    end
  endtask

  function automatic logic [5:0] sa_of(input bit which);
    return which ? sa2 : speed_angle;
  endfunction

  task automatic wait_chg(input bit which, input logic [5:0] prev,
                          output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sa_of(which) == prev && n < 40);
    if (sa_of(which) == prev) begin
      n_cmp++;
      n_bad++;
      $display("FAIL step_timeout: got %0d want change from %0d",
               sa_of(which), prev);
    end
  endtask

  initial begin
    int n;
    int rsa [5];
    int rdir [5];
    logic [5:0] prev;

    tbl[0] = '{s: 1'b0, d: 1'b1, t: 6'd63, e_sa: 63, e_dir: 1};
    tbl[1] = '{s: 1'b1, d: 1'b0, t: 6'd10, e_sa: 10, e_dir: 0};
    tbl[2] = '{s: 1'b0, d: 1'b0, t: 6'd0,  e_sa: 0,  e_dir: 1};
    tbl[3] = '{s: 1'b1, d: 1'b1, t: 6'd0,  e_sa: 0,  e_dir: 1};
    tbl[4] = '{s: 1'b0, d: 1'b0, t: 6'd63, e_sa: 63, e_dir: 0};
    tbl[5] = '{s: 1'b1, d: 1'b1, t: 6'd33, e_sa: 33, e_dir: 1};
    rsa  = '{2, 1, 0, 1, 2};
    rdir = '{1, 1, 1, 0, 0};

    repeat (3) @(negedge clk);
    chk("rst_sa", speed_angle, 0);
    chk("rst_dir", direction, 1);
    chk("rst_sel", servo_select, 0);
    chk("rst_at", at_target, 3);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("ready_first_clk", cmd_ready, 0);
    @(negedge clk);
    chk("ready_after", cmd_ready, 1);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].s, tbl[i].d, tbl[i].t, 1'b1);
      @(negedge clk);
      chk($sformatf("jump%0d_sa", i), speed_angle, tbl[i].e_sa);
      chk($sformatf("jump%0d_dir", i), direction, tbl[i].e_dir);
      chk($sformatf("jump%0d_sel", i), servo_select, tbl[i].s);
      chk($sformatf("jump%0d_at", i), at_target, 3);
      chk($sformatf("jump%0d_busy", i), busy, 0);
    end

    send(1'b0, 1'b1, 6'd0, 1'b1);
    send(1'b1, 1'b1, 6'd0, 1'b1);
    wait_phase(3);
    send(1'b1, 1'b1, 6'd5, 1'b0);
    chk("ramp_at_lag", at_target, 3);
    @(negedge clk);
    chk("ramp_at_drop", at_target, 1);
    chk("ramp_busy", busy, 1);
    prev = 6'd0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 5) chk("ramp_at_before_last", at_target, 1);
      wait_chg(1'b0, prev, n);
      chk($sformatf("ramp_sa%0d", k), speed_angle, k);
      if (k > 1) chk($sformatf("ramp_gap%0d", k), n, 16);
      prev = speed_angle;
    end
    chk("ramp_at_done", at_target, 3);
    chk("ramp_busy_done", busy, 0);
    chk("ramp_sel", servo_select, 1);

    send(1'b0, 1'b1, 6'd3, 1'b1);
    wait_phase(3);
    send(1'b0, 1'b0, 6'd2, 1'b0);
    prev = 6'd3;
    for (int k = 0; k < 5; k++) begin
      wait_chg(1'b0, prev, n);
      chk($sformatf("rev_sa%0d", k), speed_angle, rsa[k]);
      chk($sformatf("rev_dir%0d", k), direction, rdir[k]);
      if (k > 0) chk($sformatf("rev_gap%0d", k), n, 16);
      prev = speed_angle;
    end
    chk("rev_at_done", at_target, 3);

    wait_phase(1);
    send(1'b0, 1'b1, 6'd3, 1'b1);
    send(1'b0, 1'b1, 6'd10, 1'b0);
    wait_phase(0);
    send(1'b0, 1'b0, 6'd5, 1'b0);
    @(negedge clk);
    chk("coll_sa_old_tgt", speed_angle, 4);
    chk("coll_dir", direction, 1);
    chk("coll_at", at_target, 2);
    wait_phase(2);
    chk("coll_sa_new_tgt", speed_angle, 3);
    wait_phase(2);
    chk("coll_sa_next", speed_angle, 2);
    chk("coll_ch1_at", at_target[1], 1);

    send(1'b0, 1'b1, 6'd20, 1'b1);
    send(1'b0, 1'b1, 6'd40, 1'b0);
    repeat (40) @(negedge clk);
    chk("pre_reset_sa_gt20", int'(speed_angle > 6'd20), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sa", speed_angle, 0);
    chk("mid_rst_dir", direction, 1);
    chk("mid_rst_sel", servo_select, 0);
    chk("mid_rst_at", at_target, 3);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_hold_sa", speed_angle, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    @(negedge clk);
    chk("post_rst_sa", speed_angle, 0);

    s2 = 1'b1;
    d2 = 1'b1;
    t2 = 6'd3;
    j2 = 1'b0;
    v2 = 1'b1;
    @(negedge clk);
    v2 = 1'b0;
    prev = 6'd0;
    for (int k = 1; k <= 3; k++) begin
      wait_chg(1'b1, prev, n);
      chk($sformatf("p6_sa%0d", k), sa2, k);
      if (k > 1) chk($sformatf("p6_gap%0d", k), n, 6);
      prev = sa2;
    end
    chk("p6_sel", sel2, 1);
    chk("p6_dir", dir2, 1);
    chk("p6_at", at2, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/servo_ramp_sequencer.md
# servo_ramp_sequencer

Command sequencer in front of `servo_controller`. Holds a target and a current setpoint for each of the two RC servo channels: channel 0 is full-rotation, channel 1 is normal. Once per step period it slews each current setpoint one unit toward its target, and drives the shared `direction` / `speed_angle` / `servo_select` inputs of `servo_controller` from the active channel. Commands come from the PicoBlaze port-write logic over a valid/ready handshake.

## Interface
- `STEP_CYCLES`, default 2_000_000: clocks per slew step (20 ms at 100 MHz); legal range ≥ 4.
- `SIMULATE`, default 0: when 1, the step period is forced to 16 clocks.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command can be accepted.
- `cmd_servo`  in  1  target channel; 0 = full-rotation, 1 = normal.
- `cmd_dir`  in  1  requested direction; 1 = positive.
- `cmd_target`  in  6  requested magnitude, 0..63.
- `cmd_jump`  in  1  when 1, the current setpoint is loaded immediately with no ramp.
- `direction`  out  1  to `servo_controller`.
- `speed_angle`  out  6  to `servo_controller`.
- `servo_select`  out  1  to `servo_controller`; equals the active channel.
- `at_target`  out  2  bit n = 1 when channel n current == target.
- `busy`  out  1  = ~&at_target.

## Operation
- **Signed setpoints.** Each channel keeps a 7-bit signed target `t[n]` and current `c[n]`, both in range −63..+63.
  - Encoding: `cmd_dir`=1 → +`cmd_target`; `cmd_dir`=0 → −`cmd_target`.
  - −0 is stored as 0.
- **Command accept.** A command is accepted when `cmd_valid & cmd_ready`. On accept:
  - `t[cmd_servo]` ← encoded value.
  - Active channel ← `cmd_servo`.
  - If `cmd_jump`=1, `c[cmd_servo]` ← the same encoded value.
- **`cmd_ready`.** 0 while in reset, and 0 for the first clock after reset deasserts. After that it is 1 every cycle; there is no backpressure.
- **Step counter.** Counts 0..P−1, where P = 16 if `SIMULATE` else `STEP_CYCLES`. At P−1 it wraps to 0 and issues a one-cycle `tick`.
- **FSM states.**
  - `IDLE` → `STEP0` on `tick`.
  - `STEP0` → `STEP1` unconditionally.
  - `STEP1` → `IDLE` unconditionally.
- **Slew rule.** In `STEPn`:
  - c < t → c+1; c > t → c−1; c == t → hold.
  - A direction reversal therefore always passes through 0. This is mandatory, because a full-rotation servo must not be reversed at speed.
- **Output mapping** (from c of the active channel):
  - `speed_angle` = |c|, which is ≤ 63 and needs no saturation.
  - `direction` = ~c[6], so c = 0 gives `direction` = 1.
  - `servo_select` = active channel.
- **Collisions.**
  - Accept and `STEPn` for the same channel in the same cycle: the command wins. The target is updated; `c` takes the `cmd_jump` value if jump, otherwise it steps toward the **old** target.
  - The other channel is unaffected.
- **Reset mid-ramp.** All state clears asynchronously; any ramp in progress is abandoned.

## Timing
- **Reset values.**
  - `c`, `t` = 0; active channel = 0; FSM = `IDLE`; counter = 0.
  - `direction` = 1, `speed_angle` = 0, `servo_select` = 0.
  - `at_target` = 2'b11, `busy` = 0, `cmd_ready` = 0.
- **Output registers.** All outputs are registered. Updates appear the clock after the accept or `STEPn` cycle.
- **Jump latency.** Accept at edge k → new `speed_angle` / `direction` / `servo_select` valid after edge k+1.
- **Ramp duration.** A ramp of distance d completes in d ticks, i.e. d·P clocks ± 2.
- **`at_target` timing.** Deasserts one clock after an accept that creates a mismatch. Reasserts one clock after the final `STEPn`.
- **Back-to-back commands.** Accepted every cycle; the last one wins.

## Structure
- **Shared package `servo_pkg`:**
  - FSM state enum (`IDLE`, `STEP0`, `STEP1`).
  - `CH_FULLROT` = 0, `CH_NORMAL` = 1.
  - `SIM_STEP_CYCLES` = 16.
  - Encode/decode helpers between {dir, mag} and 7-bit signed.
- **Sub-module `servo_step_timer`:** the parameterised step counter, with `tick` output.
- The two-channel slew logic, the FSM and the output mux all live in the top module.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-ramp (c[0] = +20) → all outputs at reset values, including `speed_angle` = 0 and `at_target` = 11.
- **Jump.** `SIMULATE`=1; cmd {servo 0, dir 1, target 63, jump 1} → next clock `speed_angle` = 63, `direction` = 1, `servo_select` = 0, `at_target` = 11.
- **Ramp up.** cmd {servo 1, dir 1, target 5, jump 0} from 0 → `speed_angle` steps 1, 2, 3, 4, 5, one step every 16 clocks. `at_target[1]` = 0 until the 5th step, then 1.
- **Reversal.** c[0] = +3; cmd {servo 0, dir 0, target 2} → `speed_angle` sequence 2, 1, 0, 1, 2. `direction` is 1 through the step that reaches 0, then 0 from the following step.
- **Collision.** Command for channel 0 issued exactly in the `STEP0` cycle → new target stored; c moves one unit toward the old target; the next tick moves it toward the new target. Channel 1 is unchanged.
- **Period.** `SIMULATE`=0 with a 10 ns clock → tick spacing measured at 20 ms; channel 1 angle ramp 0 → 63 completes in 1.26 s ± 20 ns.
